// File: rtl/sram_responder.sv
// Word-array responder for the SP core's single-port SRAM interface, with an
// arbitrated host load/dump port, saturating core access counters and a sticky out-of-range flag.
module sram_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] sram_ADDR,
    input  logic [DATA_W-1:0] sram_DI,
    input  logic              sram_EN,
    input  logic              sram_WE,
    output logic [DATA_W-1:0] sram_DO,
    input  logic              core_busy,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              cnt_clr,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              oob_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {H_IDLE, H_ACK} host_state_t;

    host_state_t       state_reg;
    logic [DATA_W-1:0] sram_DO_reg;
    logic [DATA_W-1:0] host_rdata_reg;
    logic              host_ack_reg;
    logic [31:0]       rd_count_reg;
    logic [31:0]       wr_count_reg;
    logic              oob_err_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              core_rd;
    logic              core_wr;
    logic              host_grant;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [IDX_W-1:0]  mem_idx;
    logic              mem_in_range;
    logic              mem_we;

    assign core_rd = sram_EN && !sram_WE;
    assign core_wr = sram_EN && sram_WE;

    // The host is only granted on cycles the core leaves the array alone,
    // so a single shared address/data path serves both ports.
    assign host_grant = (state_reg == H_IDLE) && host_req && !core_busy && !sram_EN;

    assign mem_addr     = sram_EN ? sram_ADDR : host_addr;
    assign mem_wdata    = sram_EN ? sram_DI : host_wdata;
    assign mem_in_range = {1'b0, mem_addr} < (ADDR_W + 1)'(DEPTH);
    assign mem_idx      = mem_addr[IDX_W-1:0];
    assign mem_we       = mem_in_range && (core_wr || (host_grant && host_we));
    assign mem_rdata    = mem_in_range ? mem[mem_idx] : '0;

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= H_IDLE;
            sram_DO_reg    <= '0;
            host_rdata_reg <= '0;
            host_ack_reg   <= 1'b0;
            rd_count_reg   <= '0;
            wr_count_reg   <= '0;
            oob_err_reg    <= 1'b0;
        end else begin
            if (core_rd) begin
                sram_DO_reg <= mem_rdata;
            end

            case (state_reg)
                H_IDLE: begin
                    if (host_grant) begin
                        if (!host_we) begin
                            host_rdata_reg <= mem_rdata;
                        end
                        host_ack_reg <= 1'b1;
                        state_reg    <= H_ACK;
                    end
                end
                H_ACK: begin
                    host_ack_reg <= 1'b0;
                    state_reg    <= H_IDLE;
                end
                default: begin
                    host_ack_reg <= 1'b0;
                    state_reg    <= H_IDLE;
                end
            endcase

            // Clear wins over a same-edge increment or error set.
            if (cnt_clr) begin
                rd_count_reg <= '0;
                wr_count_reg <= '0;
                oob_err_reg  <= 1'b0;
            end else begin
                if (core_rd) begin
                    rd_count_reg <= sat_inc(rd_count_reg);
                end
                if (core_wr) begin
                    wr_count_reg <= sat_inc(wr_count_reg);
                end
                if ((sram_EN || host_grant) && !mem_in_range) begin
                    oob_err_reg <= 1'b1;
                end
            end
        end
    end

    assign sram_DO    = sram_DO_reg;
    assign host_ack   = host_ack_reg;
    assign host_rdata = host_rdata_reg;
    assign rd_count   = rd_count_reg;
    assign wr_count   = wr_count_reg;
    assign oob_err    = oob_err_reg;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SP core's single-port SRAM interface (sram_ADDR/DI/EN/WE/DO), as driven by the CTL state machine.
- Holds the word array and serves core reads and writes with a fixed 1-cycle read latency.
- Adds a host load/dump port, arbitrated against the core, so the bench preloads programs and reads back results through RTL rather than backdoor file dumps.
- Keeps core access counters and an out-of-range error flag.

Parameters:
ADDR_W, 16, address width of both ports
DATA_W, 32, word width
DEPTH, 1024, implemented words; addresses >= DEPTH are out of range

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset
sram_ADDR  in  ADDR_W  core word address
sram_DI  in  DATA_W  core write data
sram_EN  in  1  core access enable
sram_WE  in  1  core write enable (qualified by sram_EN)
sram_DO  out  DATA_W  core read data, registered
core_busy  in  1  core not in IDLE; blocks host grants
host_req  in  1  host request, level, held until host_ack
host_we  in  1  host write when 1, read when 0
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  host read data, valid with host_ack, then held
cnt_clr  in  1  synchronous clear of counters and oob_err
rd_count  out  32  core reads, saturating
wr_count  out  32  core writes, saturating
oob_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (reset=0, asynchronous): sram_DO=0, host_ack=0, host_rdata=0, rd_count=0, wr_count=0, oob_err=0, host FSM=H_IDLE. The memory array is not cleared; contents survive reset.
- Core read: posedge with EN=1, WE=0 sets sram_DO <= mem[ADDR]. DO is valid in the next cycle and holds until the next core read.
- Core write: posedge with EN=1, WE=1 sets mem[ADDR] <= DI. sram_DO is unchanged.
- Core has absolute priority and is never stalled; there is no wait signal on the core side.
- Out-of-range access (addr >= DEPTH) on either port:
  - writes are dropped;
  - reads return 0;
  - oob_err is set on the same edge.
- Counters: rd_count/wr_count increment per core read/write edge and saturate at 0xFFFFFFFF. Host accesses are not counted.
- cnt_clr=1 zeroes both counters and oob_err. It beats a same-edge increment or set.
- Host FSM has two states:
  - H_IDLE: at a posedge with host_req=1 && core_busy=0 && sram_EN=0, perform the access (write mem, or host_rdata <= mem[host_addr]) and go to H_ACK. Otherwise stay.
  - H_ACK: host_ack=1 for exactly this cycle, then return to H_IDLE.
- Host handshake: the host must drop host_req in the cycle host_ack is high. A req still high on return to H_IDLE starts a new access.
- Host latency: 1 cycle from grant edge to ack when unblocked; unbounded while core_busy=1.
- Same-cycle core EN and host req: the core is served and the host waits. Accesses are therefore serialized, so there is no same-address hazard.
- Reset asserted while in H_ACK: ack drops immediately. An access already performed at the grant edge remains in memory.

Test Plan:
- Host preload: core_busy=0; host writes 0xA5A5_0001 to addr 5, then reads addr 5 -> each ack one cycle after grant; host_rdata=0xA5A50001; rd_count=wr_count=0.
- Core R/W: EN=1,WE=1,ADDR=7,DI=0x1234 then EN=1,WE=0,ADDR=7 -> sram_DO=0x00001234 in the cycle after the read edge; rd_count=1, wr_count=1; DO holds through 3 idle cycles.
- Arbitration: host_req=1 read of addr 7 with core_busy=1 for 10 cycles -> no ack; core_busy drops -> ack the cycle after grant; EN=1 on the grant cycle defers the grant one further cycle.
- Out of range: core write 0xFFFF_FFFF to addr 1024 then read addr 1024 -> sram_DO=0, oob_err=1 and sticky; cnt_clr pulse -> oob_err=0 and counters=0.
- Reset persistence: write 0xDEAD_BEEF at addr 3, pulse reset low mid host ack -> all outputs 0 asynchronously; after release, core read addr 3 returns 0xDEADBEEF.
- Saturation: force rd_count to 0xFFFFFFFE, issue 3 core reads -> rd_count stays at 0xFFFFFFFF.
